// File: rtl/divisor_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle divider among N_REQ requesters.
// Latency: Ack one edge after grant; Valid follows div_Done by one edge (grant->Valid >= 3 cycles + divider latency).
// Backpressure: one operation in flight; Req is held by the requester until Ack, later Req changes wait for IDLE.
//
// Ports:
//   CLK, RSTa              clock, asynchronous active-high reset
//   Req / Ack / Valid      per-requester request, operand-capture pulse, result pulse (one-hot)
//   Num_in / Den_in        packed operands, slice i = [i*tamanyo +: tamanyo]
//   Coc / Res / DivZero    registered quotient, remainder, divide-by-zero flag
//   Busy                   high from grant until the cycle after Valid
//   div_*                  handshake to the shared divider (Start pulse, operands, results, Done)
//
// Optional build macro: DIVISOR_ZERO_CHECK_EN
//   defined   : a zero divisor is answered locally (Coc = all ones, Res = Num, DivZero = 1)
//               without starting the divider.
//   undefined : a zero divisor goes to the divider like any other operand; DivZero is tied 0.

module divisor_arbiter #(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                       CLK,
    input  logic                       RSTa,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ*tamanyo-1:0]   Num_in,
    input  logic [N_REQ*tamanyo-1:0]   Den_in,
    output logic [N_REQ-1:0]           Ack,
    output logic [N_REQ-1:0]           Valid,
    output logic [tamanyo-1:0]         Coc,
    output logic [tamanyo-1:0]         Res,
    output logic                       DivZero,
    output logic                       Busy,
    output logic                       div_Start,
    output logic [tamanyo-1:0]         div_Num,
    output logic [tamanyo-1:0]         div_Den,
    input  logic [tamanyo-1:0]         div_Coc,
    input  logic [tamanyo-1:0]         div_Res,
    input  logic                       div_Done
);

    // One extra bit so the rotated index can exceed N_REQ-1 before wrapping.
    localparam int SW = IDW + 1;
    localparam logic [SW-1:0] NREQ_W = SW'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDW-1:0]     rr;        // highest-priority requester for the next grant
    logic [IDW-1:0]     gnt;       // requester owning the operation in flight

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [tamanyo-1:0] num_arr [N_REQ];
    logic [tamanyo-1:0] den_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign num_arr[gi] = Num_in[gi*tamanyo +: tamanyo];
            assign den_arr[gi] = Den_in[gi*tamanyo +: tamanyo];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first asserted Req at or after rr, with wrap.
    // ------------------------------------------------------------------
    logic               found;
    logic [IDW-1:0]     pick;
    logic [SW-1:0]      cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr} + SW'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && Req[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pointer moves to the requester after the one just served.
    logic [IDW-1:0] rr_next;
    assign rr_next = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);

`ifdef DIVISOR_ZERO_CHECK_EN
    logic pick_den_zero;
    assign pick_den_zero = (den_arr[pick] == '0);
`else
    // Zero divisors are the divider's problem in this build.
    assign DivZero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered; pulses (Ack, Valid,
    // div_Start) default low every cycle and are raised for one edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state     <= S_IDLE;
            rr        <= '0;
            gnt       <= '0;
            Ack       <= '0;
            Valid     <= '0;
            Coc       <= '0;
            Res       <= '0;
            Busy      <= 1'b0;
            div_Start <= 1'b0;
            div_Num   <= '0;
            div_Den   <= '0;
`ifdef DIVISOR_ZERO_CHECK_EN
            DivZero   <= 1'b0;
`endif
        end else begin
            Ack       <= '0;
            Valid     <= '0;
            div_Start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt     <= pick;
                        div_Num <= num_arr[pick];
                        div_Den <= den_arr[pick];
                        Ack     <= onehot(pick);
                        Busy    <= 1'b1;
`ifdef DIVISOR_ZERO_CHECK_EN
                        if (pick_den_zero) begin
                            // Answer locally; the divider is never started.
                            Coc     <= '1;
                            Res     <= num_arr[pick];
                            DivZero <= 1'b1;
                            Valid   <= onehot(pick);
                            state   <= S_RESP;
                        end else begin
                            div_Start <= 1'b1;
                            state     <= S_ISSUE;
                        end
`else
                        div_Start <= 1'b1;
                        state     <= S_ISSUE;
`endif
                    end
                end

                // div_Start is high during this state. A Done in this
                // cycle cannot belong to the operation just started.
                S_ISSUE: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (div_Done) begin
                        Coc   <= div_Coc;
                        Res   <= div_Res;
                        Valid <= onehot(gnt);
                        state <= S_RESP;
                    end
                end

                // Valid is high during this state; Coc/Res then hold.
                S_RESP: begin
                    rr    <= rr_next;
                    Busy  <= 1'b0;
`ifdef DIVISOR_ZERO_CHECK_EN
                    DivZero <= 1'b0;
`endif
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_arbiter.sv
module tb_divisor_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic             CLK;
    logic             RSTa;
    logic [N-1:0]     Req;
    logic [N*W-1:0]   Num_in;
    logic [N*W-1:0]   Den_in;
    logic [N-1:0]     Ack;
    logic [N-1:0]     Valid;
    logic [W-1:0]     Coc;
    logic [W-1:0]     Res;
    logic             DivZero;
    logic             Busy;
    logic             div_Start;
    logic [W-1:0]     div_Num;
    logic [W-1:0]     div_Den;
    logic [W-1:0]     div_Coc;
    logic [W-1:0]     div_Res;
    logic             div_Done;

    divisor_arbiter #(.tamanyo(W), .N_REQ(N)) dut (
        .CLK(CLK), .RSTa(RSTa), .Req(Req), .Num_in(Num_in), .Den_in(Den_in),
        .Ack(Ack), .Valid(Valid), .Coc(Coc), .Res(Res), .DivZero(DivZero),
        .Busy(Busy), .div_Start(div_Start), .div_Num(div_Num), .div_Den(div_Den),
        .div_Coc(div_Coc), .div_Res(div_Res), .div_Done(div_Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int         id;
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic       dz;
    } exp_t;

    typedef struct {
        int         id;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] coc;
        logic [W-1:0] res;
    } vec_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    int   ack_cnt = 0;
    int   lat = 4;
    bit   stray = 0;
    bit   hold [N];
    bit   prev_start = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_res(input int id, input logic [W-1:0] c, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.id = id; e.coc = c; e.res = r; e.dz = dz;
        exp_q.push_back(e);
        ack_q.push_back(id);
    endtask

    task automatic drive_req(input int id, input logic [W-1:0] n, input logic [W-1:0] d);
        Num_in[id*W +: W] = n;
        Den_in[id*W +: W] = d;
        Req[id] = 1'b1;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("timeout_waiting_results");
            exp_q.delete();
            ack_q.delete();
        end
    endtask

    task automatic wait_ack(input int id, input int bound);
        int n = 0;
        while (Ack[id] !== 1'b1 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (Ack[id] !== 1'b1) fail_now("timeout_waiting_ack");
    endtask

    function automatic logic [W-1:0] oh(input int id);
        logic [W-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Divider model: variable latency, optional stray Done in the Start cycle.
    initial begin
        logic [W-1:0] n, d;
        div_Done = 1'b0;
        div_Coc  = '0;
        div_Res  = '0;
        forever begin
            @(negedge CLK);
            if (div_Start === 1'b1) begin
                n = div_Num;
                d = div_Den;
                if (stray) begin
                    div_Done = 1'b1;
                    div_Coc  = 32'hDEADBEEF;
                    div_Res  = 32'hDEADBEEF;
                    @(negedge CLK);
                    div_Done = 1'b0;
                end
                repeat (lat) @(negedge CLK);
                div_Coc  = (d == '0) ? '1 : n / d;
                div_Res  = (d == '0) ? n : n % d;
                div_Done = 1'b1;
                @(negedge CLK);
                div_Done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard: Ack order, Valid results, Start pulse width.
    initial begin
        int   e;
        exp_t x;
        forever begin
            @(negedge CLK);
            if (div_Start === 1'b1) begin
                start_cnt++;
                if (prev_start) fail_now("start_pulse_width");
            end
            prev_start = (div_Start === 1'b1);
            if (Ack !== '0) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_onehot", W'(Ack), oh(e));
                end
                for (int i = 0; i < N; i++)
                    if (Ack[i] === 1'b1 && !hold[i]) Req[i] = 1'b0;
            end
            if (Valid !== '0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    x = exp_q.pop_front();
                    chk("valid_onehot", W'(Valid), oh(x.id));
                    chk("coc", Coc, x.coc);
                    chk("res", Res, x.res);
                    chk("divzero", W'(DivZero), W'(x.dz));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},   W'(Ack), '0);
        chk({tag, "_valid"}, W'(Valid), '0);
        chk({tag, "_coc"},   Coc, '0);
        chk({tag, "_res"},   Res, '0);
        chk({tag, "_dz"},    W'(DivZero), '0);
        chk({tag, "_busy"},  W'(Busy), '0);
        chk({tag, "_start"}, W'(div_Start), '0);
        chk({tag, "_dnum"},  div_Num, '0);
        chk({tag, "_dden"},  div_Den, '0);
    endtask

    initial begin
        vec_t vt [6];
        int   s0;
        int   a0;
        int   n;

        Req    = '0;
        Num_in = '0;
        Den_in = '0;
        RSTa   = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 0;

        vt[0] = '{3, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF, 32'd0};
        vt[1] = '{2, 32'd1000,     32'd33,         32'd30,       32'd10};
        vt[2] = '{1, 32'd0,        32'd5,          32'd0,        32'd0};
        vt[3] = '{0, 32'd7,        32'd9,          32'd0,        32'd7};
        vt[4] = '{1, 32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000};
        vt[5] = '{3, 32'd12345678, 32'd1000,       32'd12345,    32'd678};

        // Reset values
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RSTa = 1'b0;
        @(negedge CLK);

        // Single request, latency 66
        lat = 66;
        s0 = start_cnt;
        expect_res(0, 32'd14, 32'd2, 1'b0);
        drive_req(0, 32'd100, 32'd7);
        @(negedge CLK);
        chk("ack_next_edge", W'(Ack), 32'h1);
        chk("start_in_issue", W'(div_Start), 32'h1);
        @(negedge CLK);
        chk("start_low_in_wait", W'(div_Start), 32'h0);
        chk("busy_in_wait", W'(Busy), 32'h1);
        chk("num_held", div_Num, 32'd100);
        chk("den_held", div_Den, 32'd7);
        wait_empty(200);
        @(negedge CLK);
        chk("busy_after", W'(Busy), 32'h0);
        chk("single_start_count", W'(start_cnt - s0), 32'd1);

        // Table of single requests
        lat = 3;
        for (int i = 0; i < 6; i++) begin
            expect_res(vt[i].id, vt[i].coc, vt[i].res, 1'b0);
            drive_req(vt[i].id, vt[i].num, vt[i].den);
            wait_empty(100);
            @(negedge CLK);
        end

        // Fairness: all held high, rr = 0, stray Done injected in ISSUE
        stray = 1;
        lat = 4;
        s0 = start_cnt;
        a0 = ack_cnt;
        for (int i = 0; i < N; i++) expect_res(i, 32'd10, W'(i), 1'b0);
        expect_res(0, 32'd10, 32'd0, 1'b0);
        for (int i = 0; i < N; i++) begin
            hold[i] = 1;
            drive_req(i, W'(50 + i), 32'd5);
        end
        n = 0;
        while ((ack_cnt - a0) < 5 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if ((ack_cnt - a0) < 5) fail_now("timeout_fairness_acks");
        for (int i = 0; i < N; i++) hold[i] = 0;
        Req = '0;
        wait_empty(200);
        chk("fair_start_count", W'(start_cnt - s0), 32'd5);
        stray = 0;
        @(negedge CLK);

        // Req[2] during WAIT of requester 1; port 1 operands change after Ack
        lat = 20;
        expect_res(1, 32'd11, 32'd0, 1'b0);
        drive_req(1, 32'd77, 32'd7);
        wait_ack(1, 20);
        repeat (3) @(negedge CLK);
        Num_in[1*W +: W] = 32'd999;
        expect_res(2, 32'd6, 32'd4, 1'b0);
        drive_req(2, 32'd40, 32'd6);
        @(negedge CLK);
        chk("no_grant_in_wait", W'(Ack), 32'h0);
        chk("num_stable_in_wait", div_Num, 32'd77);
        wait_empty(200);
        @(negedge CLK);

        // Reset during WAIT, stray Done afterwards
        lat = 30;
        ack_q.push_back(3);
        drive_req(3, 32'd10, 32'd3);
        wait_ack(3, 20);
        repeat (5) @(negedge CLK);
        RSTa = 1'b1;
        @(negedge CLK);
        check_all_zero("midreset");
        RSTa = 1'b0;
        repeat (40) @(negedge CLK);
        chk("coc_after_stray_done", Coc, 32'd0);
        chk("busy_after_stray_done", W'(Busy), 32'h0);
        lat = 3;
        expect_res(1, 32'd5, 32'd1, 1'b0);
        expect_res(3, 32'd10, 32'd0, 1'b0);
        drive_req(1, 32'd21, 32'd4);
        drive_req(3, 32'd100, 32'd10);
        wait_empty(200);
        @(negedge CLK);

        // Zero divisor
        s0 = start_cnt;
`ifdef DIVISOR_ZERO_CHECK_EN
        expect_res(0, 32'hFFFFFFFF, 32'd9, 1'b1);
`else
        expect_res(0, 32'hFFFFFFFF, 32'd9, 1'b0);
`endif
        drive_req(0, 32'd9, 32'd0);
        wait_empty(100);
`ifdef DIVISOR_ZERO_CHECK_EN
        chk("den0_start_count", W'(start_cnt - s0), 32'd0);
`else
        chk("den0_start_count", W'(start_cnt - s0), 32'd1);
`endif
        @(negedge CLK);
        chk("divzero_clears", W'(DivZero), 32'h0);
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divisor_arbiter.md
Name: divisor_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one algorithmic divider (Start/Num/Den in, Coc/Res/Done out, one operation in flight) among N_REQ requesters.
- Latches operands on grant, issues a single-cycle Start, waits for Done, and returns the registered quotient and remainder to the granted requester.
- Sits between the client blocks and the divider. It never assumes a fixed divider latency; it completes only on Done.

Parameters:
- tamanyo, 32, operand/result width in bits.
- N_REQ, 4, number of requesters (2..16).
- IDW, $clog2(N_REQ), width of the requester index.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RSTa  in  1  asynchronous, active-high reset.
- Req  in  N_REQ  Req[i]=1: requester i asks for a division; held until Ack[i].
- Num_in  in  N_REQ*tamanyo  dividends, slice i = bits [i*tamanyo +: tamanyo].
- Den_in  in  N_REQ*tamanyo  divisors, same slicing.
- Ack  out  N_REQ  one-hot, one-cycle pulse: operands of requester i captured.
- Valid  out  N_REQ  one-hot, one-cycle pulse: Coc/Res belong to requester i.
- Coc  out  tamanyo  registered quotient.
- Res  out  tamanyo  registered remainder.
- DivZero  out  1  asserted with Valid when Den was 0 (optional feature only; otherwise tied 0).
- Busy  out  1  high from grant until the cycle after Valid.
- div_Start  out  1  single-cycle start pulse to the divider.
- div_Num  out  tamanyo  latched dividend to the divider.
- div_Den  out  tamanyo  latched divisor to the divider.
- div_Coc  in  tamanyo  divider quotient.
- div_Res  in  tamanyo  divider remainder.
- div_Done  in  1  divider completion pulse.

Behaviour:
- Reset values (RSTa=1, asynchronous): state=IDLE; rr pointer=0; Ack, Valid, Coc, Res, DivZero, Busy, div_Start, div_Num, div_Den all 0.
- Reset mid-operation aborts the transaction: no Valid is issued. Any later div_Done arriving in IDLE is ignored.
- IDLE: if any Req is high, grant the first asserted Req searching from index rr upward with wrap-around. In the same edge: latch Num_in/Den_in slice into div_Num/div_Den, pulse Ack[g] for one cycle, store g, go to ISSUE.
- ISSUE: drive div_Start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold div_Num/div_Den stable. On div_Done=1, register div_Coc/div_Res into Coc/Res and go to RESP.
- RESP: Valid[g]=1 for one cycle. Coc/Res hold until the next RESP. Set rr=(g+1) mod N_REQ, go to IDLE.
- Minimum turnaround from grant to Valid is 3 cycles plus the divider latency. At most one operation is outstanding.
- Requester i must keep Req[i] and its operands stable until it sees Ack[i]. After Ack it may drop Req or raise a new request. A request held high after Ack is treated as a new request.
- Req changes during ISSUE/WAIT/RESP are ignored until IDLE.
- Fairness: with all Req high, grants rotate 0,1,...,N_REQ-1,0...
- Operands are unsigned; no width change. Coc/Res pass through bit-exact.
- A div_Done seen in ISSUE (same cycle as Start) is ignored. Only Done in WAIT completes.

Optional Feature:
- Macro: DIVISOR_ZERO_CHECK_EN.
- Defined: if the latched Den is 0 at grant, go directly from IDLE to RESP. No div_Start is issued. Outputs Coc = all ones, Res = latched Num, DivZero=1 with Valid[g]. The rr pointer advances normally.
- Undefined: Den=0 is forwarded to the divider like any other operand; DivZero is constant 0.

Test Plan:
- Single request: Req[0]=1, Num=100, Den=7, divider model with latency 66 -> Ack[0] next edge; one div_Start pulse; Valid[0] with Coc=14, Res=2; Busy low afterwards.
- All four Req held high with distinct operands (e.g. 50/5, 51/5, 52/5, 53/5) -> grant order 0,1,2,3,0; each Valid carries the correct result (10/0, 10/1, 10/2, 10/3); exactly one div_Start per grant.
- Req[2] rises during WAIT of requester 1 -> ignored until IDLE, then served; operand change on port 1 after its Ack does not affect its result.
- Assert RSTa during WAIT, then div_Done arrives -> no Valid; all outputs 0; the next request is served normally starting from rr=0.
- Den=0 with DIVISOR_ZERO_CHECK_EN, Num=9 -> no div_Start; Valid with Coc=32'hFFFFFFFF, Res=9, DivZero=1. Without the macro -> div_Start issued and DivZero=0.
- Max-boundary operands Num=32'hFFFFFFFF, Den=1 -> Coc=32'hFFFFFFFF, Res=0.
